// File: rtl/measure_pkg.sv
// Shared types and helpers for the multi-flow measurement receiver.
package measure_pkg;

    localparam logic [15:0] ETH_TYPE_IPV4  = 16'h0800;
    localparam logic [15:0] ETH_TYPE_IPV6  = 16'h86dd;
    localparam logic [39:0] DEF_MAGIC_CODE = 40'hCC_DD_EE_FF_00;

    localparam int PKG_CNT_W = 32;
    localparam int PKG_LAT_W = 24;

    typedef struct packed {
        logic [PKG_CNT_W-1:0] pps;
        logic [PKG_CNT_W-1:0] throughput;
        logic [PKG_LAT_W-1:0] lat_last;
        logic [PKG_LAT_W-1:0] lat_min;
        logic [PKG_LAT_W-1:0] lat_max;
        logic [PKG_CNT_W-1:0] loss;
    } flow_rec_t;

    localparam flow_rec_t REC_RESET = '{pps: '0, throughput: '0, lat_last: '0,
                                        lat_min: '1, lat_max: '0, loss: '0};

    function automatic logic [PKG_CNT_W-1:0] sat_add_cnt(input logic [PKG_CNT_W-1:0] a,
                                                         input logic [PKG_CNT_W-1:0] b);
        logic [PKG_CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[PKG_CNT_W] ? '1 : sum[PKG_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/measure_rx_flows_if.sv
// Receive byte stream from the rx FIFO: [8]=in-frame flag, [7:0]=byte.
interface measure_rx_flows_if;
    logic       in_valid;
    logic [8:0] in_data;

    modport master (output in_valid, in_data);
    modport slave  (input  in_valid, in_data);
endinterface

// File: rtl/measure_flow_stats.sv
// One flow's live window and snapshot record; optional sequence-loss tracking
// under MEASURE_SEQ_LOSS_EN.
module measure_flow_stats
    import measure_pkg::*;
(
    input  logic                 sys_clk,
    input  logic                 sys_rst,
`ifdef MEASURE_SEQ_LOSS_EN
    input  logic [15:0]          seq_i,
`endif
    input  logic                 commit_i,
    input  logic                 oneshot_i,
    input  logic [7:0]           len_i,
    input  logic [PKG_LAT_W-1:0] lat_i,
    output flow_rec_t            snap_o
);

    flow_rec_t live_q, live_d, base;
    flow_rec_t snap_q;
    logic [PKG_CNT_W-1:0] loss_inc;

`ifdef MEASURE_SEQ_LOSS_EN
    logic        seen_q;
    logic [15:0] expected_q;
    logic [15:0] gap;

    assign gap      = seq_i - expected_q;
    assign loss_inc = seen_q ? PKG_CNT_W'(gap) : '0;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            seen_q     <= 1'b0;
            expected_q <= '0;
        end else if (commit_i) begin
            seen_q     <= 1'b1;
            expected_q <= seq_i + 16'd1;
        end
    end
`else
    assign loss_inc = '0;
`endif

    // A commit on the oneshot cycle lands in the freshly cleared window.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        base = live_q;
        if (oneshot_i) begin
            base.pps        = '0;
            base.throughput = '0;
            base.loss       = '0;
            base.lat_min    = '1;
            base.lat_max    = '0;
        end
        live_d = base;
        if (commit_i) begin
            live_d.pps        = sat_add_cnt(base.pps, PKG_CNT_W'(1));
            live_d.throughput = sat_add_cnt(base.throughput, PKG_CNT_W'(len_i));
            live_d.loss       = sat_add_cnt(base.loss, loss_inc);
            live_d.lat_last   = lat_i;
            live_d.lat_min    = (lat_i < base.lat_min) ? lat_i : base.lat_min;
            live_d.lat_max    = (lat_i > base.lat_max) ? lat_i : base.lat_max;
        end
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (sys_rst) begin
            live_q <= REC_RESET;
            snap_q <= REC_RESET;
        end else begin
            live_q <= live_d;
            if (oneshot_i) snap_q <= live_q;
        end
    end

    assign snap_o = snap_q;

endmodule

// File: rtl/measure_rx_flows.sv
// Multi-flow measurement receiver: frame parser, per-flow stats, registered read mux.
// Define MEASURE_SEQ_LOSS_EN to enable per-flow sequence-gap counting.
module measure_rx_flows
    import measure_pkg::*;
#(
    parameter int          NUM_FLOWS    = 4,
    parameter int          CNT_W        = PKG_CNT_W,
    parameter int          LAT_W        = PKG_LAT_W,
    parameter logic [39:0] MAGIC_CODE   = DEF_MAGIC_CODE,
    parameter logic [7:0]  V4_MAGIC_OFS = 8'h2a,
    parameter logic [7:0]  V6_MAGIC_OFS = 8'h3e,
    parameter int          FLOW_W       = (NUM_FLOWS > 1) ? $clog2(NUM_FLOWS) : 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    measure_rx_flows_if.slave    rx,
    input  logic                 sec_oneshot,
    input  logic [31:0]          global_counter,
    input  logic [FLOW_W-1:0]    rd_flow,
    output logic [CNT_W-1:0]     rd_pps,
    output logic [CNT_W-1:0]     rd_throughput,
    output logic [LAT_W-1:0]     rd_lat_last,
    output logic [LAT_W-1:0]     rd_lat_min,
    output logic [LAT_W-1:0]     rd_lat_max,
    output logic [CNT_W-1:0]     rd_loss,
    output logic [15:0]          bad_flow_cnt
);

`ifdef MEASURE_SEQ_LOSS_EN
    localparam logic [7:0] MIN_TAIL = 8'd11;
    logic [15:0] seq_q;
`else
    localparam logic [7:0] MIN_TAIL = 8'd9;
`endif

    logic [7:0]           byte_idx_q, eth_hi_q, m_q, flow_q, rx_byte;
    logic                 type_ok_q, magic_ok_q;
    logic [31:0]          ts_q, lat_raw;
    logic [PKG_LAT_W-1:0] lat_q, lat_sat;
    logic [15:0]          bad_flow_q;
    logic                 frame_end, frame_ok, flow_ok, commit;
    flow_rec_t            snap [NUM_FLOWS];
    flow_rec_t            rd_sel;

    assign rx_byte   = rx.in_data[7:0];
    assign lat_raw   = global_counter - ts_q;
    assign lat_sat   = (|lat_raw[31:PKG_LAT_W]) ? '1 : lat_raw[PKG_LAT_W-1:0];
    assign frame_end = rx.in_valid & ~rx.in_data[8] & (byte_idx_q != 8'd0);
    assign frame_ok  = frame_end & type_ok_q & magic_ok_q & (byte_idx_q > m_q + MIN_TAIL);
    assign flow_ok   = 32'(flow_q) < NUM_FLOWS;
    assign commit    = frame_ok & flow_ok;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            byte_idx_q <= '0;
            eth_hi_q   <= '0;
            m_q        <= '0;
            flow_q     <= '0;
            type_ok_q  <= 1'b0;
            magic_ok_q <= 1'b0;
            ts_q       <= '0;
            lat_q      <= '0;
`ifdef MEASURE_SEQ_LOSS_EN
            seq_q      <= '0;
`endif
        end else if (rx.in_valid) begin
            if (!rx.in_data[8]) begin
                byte_idx_q <= '0;
                type_ok_q  <= 1'b0;
                magic_ok_q <= 1'b0;
            end else begin
                if (byte_idx_q != 8'hff) byte_idx_q <= byte_idx_q + 8'd1;
                if (byte_idx_q == 8'h0c) eth_hi_q <= rx_byte;
                if (byte_idx_q == 8'h0d) begin
                    type_ok_q  <= ({eth_hi_q, rx_byte} == ETH_TYPE_IPV4) ||
                                  ({eth_hi_q, rx_byte} == ETH_TYPE_IPV6);
                    magic_ok_q <= 1'b1;
                    m_q        <= ({eth_hi_q, rx_byte} == ETH_TYPE_IPV6) ? V6_MAGIC_OFS
                                                                         : V4_MAGIC_OFS;
                end
                // Magic byte 0 is the most significant byte of MAGIC_CODE.
                for (int k = 0; k < 5; k++) begin
                    if (byte_idx_q == m_q + 8'(k))
                        magic_ok_q <= magic_ok_q & (rx_byte == MAGIC_CODE[39-8*k -: 8]);
                end
                if ((byte_idx_q >= m_q + 8'd5) && (byte_idx_q <= m_q + 8'd8))
                    ts_q <= {ts_q[23:0], rx_byte};
                if (byte_idx_q == m_q + 8'd9) begin
                    flow_q <= rx_byte;
                    lat_q  <= lat_sat;
                end
`ifdef MEASURE_SEQ_LOSS_EN
                if ((byte_idx_q == m_q + 8'd10) || (byte_idx_q == m_q + 8'd11))
                    seq_q <= {seq_q[7:0], rx_byte};
`endif
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst)                                bad_flow_q <= '0;
        else if (frame_ok && !flow_ok && bad_flow_q != 16'hffff) bad_flow_q <= bad_flow_q + 16'd1;
    end
    assign bad_flow_cnt = bad_flow_q;

    for (genvar i = 0; i < NUM_FLOWS; i++) begin : g_flow
        measure_flow_stats u_stats (
            .sys_clk   (sys_clk),
            .sys_rst   (sys_rst),
`ifdef MEASURE_SEQ_LOSS_EN
            .seq_i     (seq_q),
`endif
            .commit_i  (commit && (flow_q[FLOW_W-1:0] == FLOW_W'(i))),
            .oneshot_i (sec_oneshot),
            .len_i     (byte_idx_q),
            .lat_i     (lat_q),
            .snap_o    (snap[i])
        );
    end

    assign rd_sel = (32'(rd_flow) < NUM_FLOWS) ? snap[rd_flow] : REC_RESET;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rd_pps        <= '0;
            rd_throughput <= '0;
            rd_lat_last   <= '0;
            rd_lat_min    <= '1;
            rd_lat_max    <= '0;
            rd_loss       <= '0;
        end else begin
            rd_pps        <= CNT_W'(rd_sel.pps);
            rd_throughput <= CNT_W'(rd_sel.throughput);
            rd_lat_last   <= LAT_W'(rd_sel.lat_last);
            rd_lat_min    <= LAT_W'(rd_sel.lat_min);
            rd_lat_max    <= LAT_W'(rd_sel.lat_max);
            rd_loss       <= CNT_W'(rd_sel.loss);
        end
    end

endmodule

// File: tb/tb_measure_rx_flows.sv
// Directed self-checking bench for measure_rx_flows (default or MEASURE_SEQ_LOSS_EN build).
module tb_measure_rx_flows;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        sec_oneshot = 1'b0;
    logic [31:0] global_counter = '0;
    logic [1:0]  rd_flow = '0;
    logic [31:0] rd_pps, rd_throughput, rd_loss;
    logic [23:0] rd_lat_last, rd_lat_min, rd_lat_max;
    logic [15:0] bad_flow_cnt;

    int checks = 0;
    int errors = 0;

    measure_rx_flows_if rx_if ();

    measure_rx_flows dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .rx             (rx_if),
        .sec_oneshot    (sec_oneshot),
        .global_counter (global_counter),
        .rd_flow        (rd_flow),
        .rd_pps         (rd_pps),
        .rd_throughput  (rd_throughput),
        .rd_lat_last    (rd_lat_last),
        .rd_lat_min     (rd_lat_min),
        .rd_lat_max     (rd_lat_max),
        .rd_loss        (rd_loss),
        .bad_flow_cnt   (bad_flow_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Drives one frame; optional gap byte ends it, optionally with sec_oneshot on that cycle.
    task automatic send_frame(input logic [15:0] et, input logic [7:0] m, input logic [39:0] mg,
                              input logic [31:0] ts, input logic [31:0] gc, input logic [7:0] flow,
                              input logic [15:0] seq, input int len, input bit with_end,
                              input bit os_at_end);
        logic [7:0] b;
        global_counter = gc;
        for (int i = 0; i < len; i++) begin
            b = 8'(i);
            if (i == 12) b = et[15:8];
            if (i == 13) b = et[7:0];
            if (i >= m && i < m + 5) b = mg[39-8*(i-m) -: 8];
            if (i >= m + 5 && i < m + 9) b = ts[31-8*(i-m-5) -: 8];
            if (i == m + 9) b = flow;
            if (i == m + 10) b = seq[15:8];
            if (i == m + 11) b = seq[7:0];
            tick();
            rx_if.in_valid = 1'b1;
            rx_if.in_data  = {1'b1, b};
        end
        tick();
        rx_if.in_valid = with_end;
        rx_if.in_data  = 9'h000;
        sec_oneshot    = os_at_end;
        tick();
        rx_if.in_valid = 1'b0;
        sec_oneshot    = 1'b0;
    endtask

    task automatic pulse_oneshot();
        tick();
        sec_oneshot = 1'b1;
        tick();
        sec_oneshot = 1'b0;
    endtask

    task automatic select_flow(input logic [1:0] f);
        tick();
        rd_flow = f;
        tick();
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        rx_if.in_valid = 1'b0;
        rx_if.in_data  = '0;
        tick(); tick();
        sys_rst = 1'b0;
        tick();
        checks++; if (rd_pps !== 32'd0) begin errors++; $display("FAIL reset_pps: got %0h want 0", rd_pps); end
        checks++; if (rd_throughput !== 32'd0) begin errors++; $display("FAIL reset_thr: got %0h want 0", rd_throughput); end
        checks++; if (rd_lat_min !== 24'hffffff) begin errors++; $display("FAIL reset_lat_min: got %0h want ffffff", rd_lat_min); end
        checks++; if (rd_lat_max !== 24'd0) begin errors++; $display("FAIL reset_lat_max: got %0h want 0", rd_lat_max); end
        checks++; if (rd_lat_last !== 24'd0) begin errors++; $display("FAIL reset_lat_last: got %0h want 0", rd_lat_last); end
        checks++; if (rd_loss !== 32'd0) begin errors++; $display("FAIL reset_loss: got %0h want 0", rd_loss); end
        checks++; if (bad_flow_cnt !== 16'd0) begin errors++; $display("FAIL reset_bad: got %0h want 0", bad_flow_cnt); end
    endtask

    task automatic test_ipv4_basic();
        send_frame(16'h0800, 8'h2a, 40'hCCDDEEFF00, 32'd1000, 32'd1250, 8'd1, 16'd0, 64, 1'b1, 1'b0);
        pulse_oneshot();
        select_flow(2'd1);
        checks++; if (rd_pps !== 32'd1) begin errors++; $display("FAIL v4_pps: got %0d want 1", rd_pps); end
        checks++; if (rd_throughput !== 32'd64) begin errors++; $display("FAIL v4_thr: got %0d want 64", rd_throughput); end
        checks++; if (rd_lat_last !== 24'd250) begin errors++; $display("FAIL v4_last: got %0d want 250", rd_lat_last); end
        checks++; if (rd_lat_min !== 24'd250) begin errors++; $display("FAIL v4_min: got %0d want 250", rd_lat_min); end
        checks++; if (rd_lat_max !== 24'd250) begin errors++; $display("FAIL v4_max: got %0d want 250", rd_lat_max); end
        select_flow(2'd0);
        checks++; if (rd_pps !== 32'd0) begin errors++; $display("FAIL v4_other_pps: got %0d want 0", rd_pps); end
        checks++; if (rd_lat_min !== 24'hffffff) begin errors++; $display("FAIL v4_other_min: got %0h want ffffff", rd_lat_min); end
        checks++; if (rd_lat_max !== 24'd0) begin errors++; $display("FAIL v4_other_max: got %0h want 0", rd_lat_max); end
    endtask

    task automatic test_ipv6_multi();
        send_frame(16'h86dd, 8'h3e, 40'hCCDDEEFF00, 32'd100, 32'd110, 8'd2, 16'd0, 80, 1'b1, 1'b0);
        send_frame(16'h86dd, 8'h3e, 40'hCCDDEEFF00, 32'd100, 32'd130, 8'd2, 16'd0, 80, 1'b1, 1'b0);
        send_frame(16'h86dd, 8'h3e, 40'hCCDDEEFF00, 32'd100, 32'd120, 8'd2, 16'd0, 80, 1'b1, 1'b0);
        pulse_oneshot();
        select_flow(2'd0);
        rd_flow = 2'd2;
        @(negedge sys_clk);
        checks++; if (rd_pps !== 32'd0) begin errors++; $display("FAIL v6_latency_old: got %0d want 0", rd_pps); end
        tick();
        checks++; if (rd_pps !== 32'd3) begin errors++; $display("FAIL v6_pps: got %0d want 3", rd_pps); end
        checks++; if (rd_throughput !== 32'd240) begin errors++; $display("FAIL v6_thr: got %0d want 240", rd_throughput); end
        checks++; if (rd_lat_min !== 24'd10) begin errors++; $display("FAIL v6_min: got %0d want 10", rd_lat_min); end
        checks++; if (rd_lat_max !== 24'd30) begin errors++; $display("FAIL v6_max: got %0d want 30", rd_lat_max); end
        checks++; if (rd_lat_last !== 24'd20) begin errors++; $display("FAIL v6_last: got %0d want 20", rd_lat_last); end
    endtask

    task automatic test_commit_oneshot();
        send_frame(16'h0800, 8'h2a, 40'hCCDDEEFF00, 32'd0, 32'd5, 8'd0, 16'd3, 64, 1'b1, 1'b0);
        send_frame(16'h0800, 8'h2a, 40'hCCDDEEFF00, 32'd0, 32'd7, 8'd0, 16'd4, 64, 1'b1, 1'b1);
        select_flow(2'd0);
        checks++; if (rd_pps !== 32'd1) begin errors++; $display("FAIL coin_snap_pps: got %0d want 1", rd_pps); end
        checks++; if (rd_lat_last !== 24'd5) begin errors++; $display("FAIL coin_snap_last: got %0d want 5", rd_lat_last); end
        pulse_oneshot();
        tick();
        checks++; if (rd_pps !== 32'd1) begin errors++; $display("FAIL coin_next_pps: got %0d want 1", rd_pps); end
        checks++; if (rd_lat_min !== 24'd7) begin errors++; $display("FAIL coin_next_min: got %0d want 7", rd_lat_min); end
        checks++; if (rd_throughput !== 32'd64) begin errors++; $display("FAIL coin_next_thr: got %0d want 64", rd_throughput); end
    endtask

    task automatic test_seq_loss();
        logic [31:0] exp_loss;
`ifdef MEASURE_SEQ_LOSS_EN
        exp_loss = 32'd2;
`else
        exp_loss = 32'd0;
`endif
        send_frame(16'h0800, 8'h2a, 40'hCCDDEEFF00, 32'd0, 32'd1, 8'd0, 16'd5, 64, 1'b1, 1'b0);
        send_frame(16'h0800, 8'h2a, 40'hCCDDEEFF00, 32'd0, 32'd1, 8'd0, 16'd6, 64, 1'b1, 1'b0);
        send_frame(16'h0800, 8'h2a, 40'hCCDDEEFF00, 32'd0, 32'd1, 8'd0, 16'd9, 64, 1'b1, 1'b0);
        pulse_oneshot();
        select_flow(2'd0);
        checks++; if (rd_loss !== exp_loss) begin errors++; $display("FAIL seq_loss: got %0d want %0d", rd_loss, exp_loss); end
        checks++; if (rd_pps !== 32'd3) begin errors++; $display("FAIL seq_pps: got %0d want 3", rd_pps); end
    endtask

    task automatic test_bad_flow();
        send_frame(16'h0800, 8'h2a, 40'hCCDDEEFF00, 32'd0, 32'd1, 8'd7, 16'd0, 64, 1'b1, 1'b0);
        checks++; if (bad_flow_cnt !== 16'd1) begin errors++; $display("FAIL bad_cnt: got %0d want 1", bad_flow_cnt); end
        send_frame(16'h0800, 8'h2a, 40'hCCDDEEFF00, 32'd0, 32'd1, 8'd1, 16'd0, 48, 1'b1, 1'b0);
        send_frame(16'h0800, 8'h2a, 40'hCCDDEEFF01, 32'd0, 32'd1, 8'd1, 16'd0, 64, 1'b1, 1'b0);
        send_frame(16'h0806, 8'h2a, 40'hCCDDEEFF00, 32'd0, 32'd1, 8'd1, 16'd0, 64, 1'b1, 1'b0);
        checks++; if (bad_flow_cnt !== 16'd1) begin errors++; $display("FAIL bad_cnt_hold: got %0d want 1", bad_flow_cnt); end
        pulse_oneshot();
        for (int f = 0; f < 4; f++) begin
            select_flow(2'(f));
            checks++; if (rd_pps !== 32'd0) begin errors++; $display("FAIL drop_pps_f%0d: got %0d want 0", f, rd_pps); end
        end
    endtask

    task automatic test_latency_edges();
        send_frame(16'h0800, 8'h2a, 40'hCCDDEEFF00, 32'hffff_fff0, 32'h10, 8'd3, 16'd0, 64, 1'b1, 1'b0);
        send_frame(16'h0800, 8'h2a, 40'hCCDDEEFF00, 32'd0, 32'h0200_0000, 8'd3, 16'd1, 64, 1'b1, 1'b0);
        pulse_oneshot();
        select_flow(2'd3);
        checks++; if (rd_lat_min !== 24'd32) begin errors++; $display("FAIL lat_wrap_min: got %0h want 20", rd_lat_min); end
        checks++; if (rd_lat_max !== 24'hffffff) begin errors++; $display("FAIL lat_sat_max: got %0h want ffffff", rd_lat_max); end
        checks++; if (rd_lat_last !== 24'hffffff) begin errors++; $display("FAIL lat_sat_last: got %0h want ffffff", rd_lat_last); end
    endtask

    task automatic test_long_frame();
        send_frame(16'h0800, 8'h2a, 40'hCCDDEEFF00, 32'd0, 32'd9, 8'd1, 16'd0, 300, 1'b1, 1'b0);
        pulse_oneshot();
        select_flow(2'd1);
        checks++; if (rd_throughput !== 32'd255) begin errors++; $display("FAIL long_thr: got %0d want 255", rd_throughput); end
        checks++; if (rd_pps !== 32'd1) begin errors++; $display("FAIL long_pps: got %0d want 1", rd_pps); end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(16'h0800, 8'h2a, 40'hCCDDEEFF00, 32'd0, 32'd4, 8'd1, 16'd0, 60, 1'b0, 1'b0);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        rx_if.in_valid = 1'b1;
        rx_if.in_data  = 9'h000;
        tick();
        rx_if.in_valid = 1'b0;
        pulse_oneshot();
        select_flow(2'd1);
        checks++; if (rd_pps !== 32'd0) begin errors++; $display("FAIL midrst_pps: got %0d want 0", rd_pps); end
        checks++; if (bad_flow_cnt !== 16'd0) begin errors++; $display("FAIL midrst_bad: got %0d want 0", bad_flow_cnt); end
        checks++; if (rd_lat_min !== 24'hffffff) begin errors++; $display("FAIL midrst_min: got %0h want ffffff", rd_lat_min); end
    endtask

    initial begin
        test_reset();
        test_ipv4_basic();
        test_ipv6_multi();
        test_commit_oneshot();
        test_seq_loss();
        test_bad_flow();
        test_latency_edges();
        test_long_frame();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
